// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 encrypt/crack block family.
package arc4_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ_LEN,
    ST_INIT,
    ST_KSA,
    ST_PRGA,
    ST_DONE
  } state_t;

  localparam int unsigned S_SIZE    = 256;
  localparam int unsigned KEY_BYTES = 3;

  // Printable-ASCII window used by the crack blocks to judge candidate keys
  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  // Byte 0 of the key is the most significant byte
  function automatic logic [7:0] key_byte(input logic [23:0] key, input logic [1:0] idx);
    case (idx)
      2'd0:    return key[23:16];
      2'd1:    return key[15:8];
      default: return key[7:0];
    endcase
  endfunction

endpackage

// File: rtl/arc4_encrypt_s_ram.sv
// 256x8 single-port state RAM; synchronous read returns the pre-write contents.
module s_ram (
  input  logic       clk,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic       we,
  output logic [7:0] rdata
);

  logic [7:0] mem [256];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/arc4_encrypt.sv
// ARC4 encryptor: reads a length-prefixed plaintext buffer and writes the
// length-prefixed ciphertext, one byte per ct_wren cycle.
module arc4_encrypt
  import arc4_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        rdy,
  input  logic [23:0] key,
  output logic [7:0]  pt_addr,
  input  logic [7:0]  pt_rddata,
  output logic [7:0]  ct_addr,
  output logic [7:0]  ct_wrdata,
  output logic        ct_wren
);

  state_t      state;
  logic [2:0]  phase;
  logic [7:0]  i, j, k, len, si, sj;
  logic [1:0]  kidx;
  logic [23:0] key_r;

  logic [7:0]  s_addr, s_wdata, s_rdata;
  logic        s_we;
  logic [7:0]  j_ksa, j_prga;

  s_ram u_s_ram (
    .clk   (clk),
    .addr  (s_addr),
    .wdata (s_wdata),
    .we    (s_we),
    .rdata (s_rdata)
  );

  assign j_ksa  = j + s_rdata + key_byte(key_r, kidx);
  assign j_prga = j + s_rdata;

  // Each swap is read S[i], read S[j], write S[i], write S[j]: with i==j both
  // reads see the original value, so the two writes leave S unchanged.
  always_comb begin
    s_addr  = '0;
    s_wdata = '0;
    s_we    = 1'b0;
    case (state)
      ST_INIT: begin
        s_addr  = i;
        s_wdata = i;
        s_we    = 1'b1;
      end
      ST_KSA: begin
        case (phase)
          3'd0: s_addr = i;
          3'd1: s_addr = j_ksa;
          3'd2: begin s_addr = i; s_wdata = s_rdata; s_we = 1'b1; end
          3'd3: begin s_addr = j; s_wdata = si;      s_we = 1'b1; end
          default: ;
        endcase
      end
      ST_PRGA: begin
        case (phase)
          3'd0: s_addr = i + 8'd1;
          3'd1: s_addr = j_prga;
          3'd2: begin s_addr = i; s_wdata = s_rdata; s_we = 1'b1; end
          3'd3: begin s_addr = j; s_wdata = si;      s_we = 1'b1; end
          3'd4: s_addr = si + sj;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      phase     <= '0;
      i         <= '0;
      j         <= '0;
      k         <= '0;
      len       <= '0;
      si        <= '0;
      sj        <= '0;
      kidx      <= '0;
      key_r     <= '0;
      rdy       <= 1'b1;
      pt_addr   <= '0;
      ct_addr   <= '0;
      ct_wrdata <= '0;
      ct_wren   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          ct_wren <= 1'b0;
          pt_addr <= '0;
          if (en) begin
            key_r <= key;
            rdy   <= 1'b0;
            phase <= '0;
            state <= ST_READ_LEN;
          end
        end

        ST_READ_LEN: begin
          case (phase)
            3'd0: phase <= 3'd1;
            3'd1: begin
              len       <= pt_rddata;
              ct_wren   <= 1'b1;
              ct_addr   <= '0;
              ct_wrdata <= pt_rddata;
              phase     <= 3'd2;
            end
            default: begin
              ct_wren <= 1'b0;
              i       <= '0;
              phase   <= '0;
              state   <= ST_INIT;
            end
          endcase
        end

        ST_INIT: begin
          i <= i + 8'd1;
          if (i == 8'(S_SIZE - 1)) begin
            j     <= '0;
            kidx  <= '0;
            phase <= '0;
            state <= ST_KSA;
          end
        end

        ST_KSA: begin
          case (phase)
            3'd0: phase <= 3'd1;
            3'd1: begin
              si    <= s_rdata;
              j     <= j_ksa;
              phase <= 3'd2;
            end
            3'd2: phase <= 3'd3;
            default: begin
              phase <= '0;
              i     <= i + 8'd1;
              kidx  <= (kidx == 2'(KEY_BYTES - 1)) ? 2'd0 : kidx + 2'd1;
              if (i == 8'(S_SIZE - 1)) begin
                j     <= '0;
                k     <= 8'd1;
                state <= (len == 8'd0) ? ST_DONE : ST_PRGA;
              end
            end
          endcase
        end

        ST_PRGA: begin
          case (phase)
            3'd0: begin
              i       <= i + 8'd1;
              pt_addr <= k;
              phase   <= 3'd1;
            end
            3'd1: begin
              si    <= s_rdata;
              j     <= j_prga;
              phase <= 3'd2;
            end
            3'd2: begin
              sj    <= s_rdata;
              phase <= 3'd3;
            end
            3'd3: phase <= 3'd4;
            3'd4: phase <= 3'd5;
            3'd5: begin
              ct_wren   <= 1'b1;
              ct_addr   <= k;
              ct_wrdata <= pt_rddata ^ s_rdata;
              phase     <= 3'd6;
            end
            default: begin
              // Compare before incrementing so L=255 never wraps k to 0
              ct_wren <= 1'b0;
              phase   <= '0;
              if (k == len) state <= ST_DONE;
              else          k     <= k + 8'd1;
            end
          endcase
        end

        ST_DONE: begin
          ct_wren <= 1'b0;
          pt_addr <= '0;
          rdy     <= 1'b1;
          state   <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arc4_encrypt.sv
// Scoreboard bench for arc4_encrypt: expected ct writes are queued at start
// and matched against the DUT's ct write stream.
module tb_arc4_encrypt;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  localparam int BOUND = 4000;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [7:0]  pt_addr;
  logic [7:0]  pt_rddata;
  logic [7:0]  ct_addr;
  logic [7:0]  ct_wrdata;
  logic        ct_wren;

  logic [7:0]  pt_mem [256];
  logic [7:0]  ct_mem [256];
  logic [7:0]  ks     [256];
  wr_t         sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int rst_wr   = 0;

  arc4_encrypt dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .rdy       (rdy),
    .key       (key),
    .pt_addr   (pt_addr),
    .pt_rddata (pt_rddata),
    .ct_addr   (ct_addr),
    .ct_wrdata (ct_wrdata),
    .ct_wren   (ct_wren)
  );

  always #5 clk = ~clk;

  always @(posedge clk) pt_rddata <= pt_mem[pt_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ct_wren) begin
      if (rst) rst_wr++;
      else begin
        ct_mem[ct_addr] = ct_wrdata;
        if (sb.size() == 0) check("unexp_wr_addr", {24'd0, ct_addr}, 32'hDEAD);
        else begin
          wr_t e;
          e = sb.pop_front();
          check("ct_addr", {24'd0, ct_addr}, {24'd0, e.addr});
          check("ct_data", {24'd0, ct_wrdata}, {24'd0, e.data});
        end
      end
    end
  end

  // Reference ARC4 keystream: ks[1..n]
  task automatic gen_ks(input logic [23:0] k, input int n);
    logic [7:0] s [256];
    logic [7:0] kb [3];
    logic [7:0] a, b, t;
    kb[0] = k[23:16]; kb[1] = k[15:8]; kb[2] = k[7:0];
    for (int x = 0; x < 256; x++) s[x] = 8'(x);
    b = 0;
    for (int x = 0; x < 256; x++) begin
      b = b + s[x] + kb[x % 3];
      t = s[x]; s[x] = s[b]; s[b] = t;
    end
    a = 0; b = 0;
    for (int x = 1; x <= n; x++) begin
      a = a + 8'd1;
      b = b + s[a];
      t = s[a]; s[a] = s[b]; s[b] = t;
      ks[x] = s[8'(s[a] + s[b])];
    end
  endtask

  task automatic push_model(input logic [23:0] k);
    int n;
    n = int'(pt_mem[0]);
    gen_ks(k, n);
    sb.push_back('{addr: 8'd0, data: pt_mem[0]});
    for (int x = 1; x <= n; x++) sb.push_back('{addr: 8'(x), data: pt_mem[x] ^ ks[x]});
  endtask

  task automatic start_and_wait(input logic hold_en, output int cycles);
    @(negedge clk);
    check("rdy_before_start", {31'd0, rdy}, 32'd1);
    en = 1'b1;
    @(negedge clk);
    check("rdy_busy", {31'd0, rdy}, 32'd0);
    if (!hold_en) en = 1'b0;
    cycles = 1;
    while (!rdy && cycles < BOUND) begin
      @(negedge clk);
      cycles++;
    end
    en = 1'b0;
    check("rdy_return", {31'd0, rdy}, 32'd1);
  endtask

  task automatic load_plaintext();
    string s;
    s = "Plaintext";
    pt_mem[0] = 8'd9;
    for (int x = 0; x < 9; x++) pt_mem[x + 1] = s[x];
  endtask

  task automatic push_known();
    logic [7:0] exp [9];
    exp = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    sb.push_back('{addr: 8'd0, data: 8'h09});
    for (int x = 0; x < 9; x++) sb.push_back('{addr: 8'(x + 1), data: exp[x]});
  endtask

  initial begin
    int lat_a, lat_b, lat_c, lat_x, errs;
    logic [23:0] k255;

    for (int x = 0; x < 256; x++) pt_mem[x] = 8'h00;
    rst = 1'b1; en = 1'b0; key = '0;
    repeat (2) @(negedge clk);
    check("rst_rdy", {31'd0, rdy}, 32'd1);
    check("rst_wren", {31'd0, ct_wren}, 32'd0);
    check("rst_ct_addr", {24'd0, ct_addr}, 32'd0);
    check("rst_ct_data", {24'd0, ct_wrdata}, 32'd0);
    check("rst_pt_addr", {24'd0, pt_addr}, 32'd0);
    rst = 1'b0;

    // Known vector
    load_plaintext();
    key = 24'h4B6579;
    push_known();
    start_and_wait(1'b0, lat_a);
    check("sb_empty_known", sb.size(), 32'd0);

    // L = 0
    pt_mem[0] = 8'd0;
    key = 24'($urandom);
    sb.push_back('{addr: 8'd0, data: 8'd0});
    start_and_wait(1'b0, lat_x);
    repeat (20) @(negedge clk);
    check("sb_empty_l0", sb.size(), 32'd0);

    // L = 255, random key and message, then decrypt collected ct
    k255 = 24'($urandom);
    key  = k255;
    pt_mem[0] = 8'd255;
    for (int x = 1; x < 256; x++) pt_mem[x] = 8'($urandom);
    push_model(k255);
    start_and_wait(1'b0, lat_x);
    check("sb_empty_l255", sb.size(), 32'd0);
    gen_ks(k255, 255);
    errs = 0;
    for (int x = 1; x < 256; x++) if ((ct_mem[x] ^ ks[x]) !== pt_mem[x]) errs++;
    check("decrypt_l255", errs, 32'd0);

    // Reset mid-KSA: only ct[0] escapes before the abort
    load_plaintext();
    key = 24'h4B6579;
    sb.push_back('{addr: 8'd0, data: 8'h09});
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (700) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_rdy", {31'd0, rdy}, 32'd1);
    check("midrst_wren", {31'd0, ct_wren}, 32'd0);
    check("midrst_pt_addr", {24'd0, pt_addr}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("sb_empty_abort", sb.size(), 32'd0);
    push_known();
    start_and_wait(1'b0, lat_b);
    check("sb_empty_rerun", sb.size(), 32'd0);
    check("rst_writes", rst_wr, 32'd0);
    check("latency_rerun", lat_b, lat_a);

    // en held high, key changed mid-run: one run with the start key
    key = 24'h4B6579;
    push_known();
    fork
      start_and_wait(1'b1, lat_c);
      begin
        repeat (50) @(negedge clk);
        key = 24'h123456;
      end
    join
    repeat (30) @(negedge clk);
    check("held_rdy_stays", {31'd0, rdy}, 32'd1);
    check("sb_empty_held", sb.size(), 32'd0);
    check("latency_held", lat_c, lat_a);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arc4_encrypt.md
ARC4_ENCRYPT -- requirements
Module: arc4_encrypt

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 en  input  1  start request; sampled only while rdy=1.
REQ-004 rdy  output  1  idle/ready indicator.
REQ-005 key  input  24  ARC4 key; key[23:16]=byte0, key[15:8]=byte1, key[7:0]=byte2.
REQ-006 pt_addr  output  8  plaintext memory address; memory has 1-cycle synchronous read.
REQ-007 pt_rddata  input  8  plaintext read data; pt[0]=length L, pt[1..L]=message.
REQ-008 ct_addr  output  8  ciphertext memory address.
REQ-009 ct_wrdata  output  8  ciphertext write data.
REQ-010 ct_wren  output  1  ciphertext write strobe; one byte written per asserted cycle.

Function
REQ-011 The module SHALL latch key and L at start; key changes during a run are ignored.
REQ-012 Handshake: en=1 while rdy=1 starts a run; rdy deasserts the next cycle; en while rdy=0 is ignored.
REQ-013 States: IDLE, READ_LEN, INIT, KSA, PRGA, DONE.
REQ-014 IDLE: rdy=1, ct_wren=0; en=1 -> READ_LEN.
REQ-015 READ_LEN: reads pt[0], writes ct[0]=L exactly once, then -> INIT.
REQ-016 INIT: S[i]=i for i=0..255, one write per cycle (256 cycles), then -> KSA.
REQ-017 KSA: for i=0..255, j=(j+S[i]+keybyte[i mod 3]) mod 256, swap S[i],S[j]; j starts at 0.
REQ-018 PRGA: i=j=0; for k=1..L: i=i+1; j=j+S[i]; swap; pad=S[(S[i]+S[j]) mod 256]; ct[k]=pt[k] XOR pad.
REQ-019 All index arithmetic SHALL be 8-bit, wrapping mod 256 without carry.
REQ-020 KSA and PRGA swaps with i==j SHALL leave S unchanged (read-before-write ordering).
REQ-021 L=0: after KSA, skip PRGA, go straight to DONE; only ct[0]=0 is written.
REQ-022 L=255: ct[255] is the last write; the k counter SHALL NOT wrap to 0.
REQ-023 ct writes SHALL occur in ascending address order, each address exactly once per run.
REQ-024 DONE: one cycle, then IDLE with rdy=1; en already high in DONE is not a start.
REQ-025 ct_wren SHALL be 0 in every state except the ct-write cycles of READ_LEN and PRGA.
REQ-026 Total run latency SHALL be deterministic for a given L; the bench measures it, not the spec.

Reset
REQ-027 rst=1 forces IDLE immediately: rdy=1, ct_wren=0, ct_addr=0, ct_wrdata=0, pt_addr=0.
REQ-028 rst during any state aborts the run; no ct write occurs while rst=1 or on the release edge.
REQ-029 After rst release, a new run SHALL complete correctly; stale S contents are irrelevant because INIT rewrites them.

Structure
REQ-030 Shared package arc4_pkg: state enum type, S_SIZE=256, KEY_BYTES=3, printable bounds 8'h20/8'h7E for crack blocks.
REQ-031 S storage is one sub-module s_ram: 256x8 single-port RAM, 1-cycle synchronous read, write-first disabled.
REQ-032 The cracker blocks reuse arc4_encrypt output as their stimulus ciphertext; its ct memory format matches their ct input format.

Verification
REQ-033 key=24'h4B6579, pt="Plaintext" (L=9) -> ct[0]=09, ct[1..9]=BB F3 16 E8 D9 40 AF 0A D3; rdy returns 1.
REQ-034 L=0, any key -> exactly one ct write (addr 0, data 00); rdy returns 1; no further ct_wren.
REQ-035 L=255, random key -> 256 writes, addresses 0..255 in order; decrypting with the same key reproduces pt.
REQ-036 rst pulsed mid-KSA, then a fresh start with vector REQ-033 -> identical ciphertext; no writes during or on the release edge of rst.
REQ-037 en held high through a run and key changed mid-run -> a single run only; output uses the start key; restarts only after rdy=1 is observed.
